alu_share_arb: RTL and testbench

- Sequencer/arbiter that shares one combinational 32-bit ALU between two requesters (e.g. execute stage and branch-compare unit).
- Arbitrates round-robin, captures the winner's operands, and drives the external ALU from registered operands.
- Registers ALU result and flags, returns them with a one-cycle done pulse tagged with requester ID.
- Screens out unsupported opcodes before they reach the ALU.

---
 rtl/alu_share_arb.sv | 134 +++++++++++++
 tb/tb_alu_share_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Define ALU_SHARE_ARB_FIXED_PRI_EN for fixed priority (requester 0 always wins contention).
//
// state | meaning
// IDLE  | waiting for a request; grant evaluated and operands captured here
// EXEC  | ALU driven from captured operands, Req_Ack pulsed
// RESP  | result registered, Done pulsed, no grant evaluated
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        Req_Valid,
  input  logic [DATA_W-1:0] Req_A0,
  input  logic [DATA_W-1:0] Req_B0,
  input  logic [SEL_W-1:0]  Req_Sel0,
  input  logic [DATA_W-1:0] Req_A1,
  input  logic [DATA_W-1:0] Req_B1,
  input  logic [SEL_W-1:0]  Req_Sel1,
  output logic [1:0]        Req_Ack,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] ALU_Out,
  input  logic              ALU_Carry,
  input  logic              ALU_Zero,
  input  logic              ALU_Ovf,
  output logic [DATA_W-1:0] Rsp_Out,
  output logic              Rsp_Carry,
  output logic              Rsp_Zero,
  output logic              Rsp_Ovf,
  output logic              Rsp_Id,
  output logic              Rsp_Err,
  output logic [1:0]        Done,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             gnt_id;
  logic             illegal;
  logic             gnt;
  logic [SEL_W-1:0] sel_pick;
  logic             sel_legal;
`ifndef ALU_SHARE_ARB_FIXED_PRI_EN
  logic             last_grant;
`endif

  function automatic logic is_legal(input logic [SEL_W-1:0] sel);
    case (sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0110,
      4'b0111, 4'b1100, 4'b1111: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    gnt = 1'b0;
    if (Req_Valid == 2'b10) begin
      gnt = 1'b1;
    end else if (Req_Valid == 2'b11) begin
`ifdef ALU_SHARE_ARB_FIXED_PRI_EN
      gnt = 1'b0;
`else
      gnt = ~last_grant;
`endif
    end
  end

  assign sel_pick  = gnt ? Req_Sel1 : Req_Sel0;
  assign sel_legal = is_legal(sel_pick);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt_id    <= 1'b0;
      illegal   <= 1'b0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_Sel   <= '0;
      Rsp_Out   <= '0;
      Rsp_Carry <= 1'b0;
      Rsp_Zero  <= 1'b0;
      Rsp_Ovf   <= 1'b0;
      Rsp_Id    <= 1'b0;
      Rsp_Err   <= 1'b0;
      Req_Ack   <= 2'b00;
      Done      <= 2'b00;
      Busy      <= 1'b0;
`ifndef ALU_SHARE_ARB_FIXED_PRI_EN
      last_grant <= 1'b1;
`endif
    end else begin
      Req_Ack <= 2'b00;
      Done    <= 2'b00;
      case (state)
        IDLE: begin
          if (Req_Valid != 2'b00) begin
            ALU_A   <= gnt ? Req_A1 : Req_A0;
            ALU_B   <= gnt ? Req_B1 : Req_B0;
            // illegal opcodes never reach the ALU
            ALU_Sel <= sel_legal ? sel_pick : '0;
            gnt_id  <= gnt;
            illegal <= ~sel_legal;
            Req_Ack <= gnt ? 2'b10 : 2'b01;
            Busy    <= 1'b1;
            state   <= EXEC;
`ifndef ALU_SHARE_ARB_FIXED_PRI_EN
            last_grant <= gnt;
`endif
          end
        end
        EXEC: begin
          Rsp_Out   <= illegal ? '0 : ALU_Out;
          Rsp_Carry <= ~illegal & ALU_Carry;
          Rsp_Zero  <= ~illegal & ALU_Zero;
          Rsp_Ovf   <= ~illegal & ALU_Ovf;
          Rsp_Id    <= gnt_id;
          Rsp_Err   <= illegal;
          Done      <= gnt_id ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural model of the shared ALU.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  Req_Valid = 2'b00;
  logic [31:0] Req_A0 = '0, Req_B0 = '0, Req_A1 = '0, Req_B1 = '0;
  logic [3:0]  Req_Sel0 = '0, Req_Sel1 = '0;
  logic [1:0]  Req_Ack;
  logic [31:0] ALU_A, ALU_B, ALU_Out, Rsp_Out;
  logic [3:0]  ALU_Sel;
  logic        ALU_Carry, ALU_Zero, ALU_Ovf;
  logic        Rsp_Carry, Rsp_Zero, Rsp_Ovf, Rsp_Id, Rsp_Err, Busy;
  logic [1:0]  Done;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .reset_n(reset_n), .Req_Valid(Req_Valid),
    .Req_A0(Req_A0), .Req_B0(Req_B0), .Req_Sel0(Req_Sel0),
    .Req_A1(Req_A1), .Req_B1(Req_B1), .Req_Sel1(Req_Sel1),
    .Req_Ack(Req_Ack), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .ALU_Carry(ALU_Carry), .ALU_Zero(ALU_Zero), .ALU_Ovf(ALU_Ovf),
    .Rsp_Out(Rsp_Out), .Rsp_Carry(Rsp_Carry), .Rsp_Zero(Rsp_Zero), .Rsp_Ovf(Rsp_Ovf),
    .Rsp_Id(Rsp_Id), .Rsp_Err(Rsp_Err), .Done(Done), .Busy(Busy)
  );

  // external combinational ALU
  logic [32:0] sum;
  always_comb begin
    sum       = '0;
    ALU_Out   = '0;
    ALU_Carry = 1'b0;
    ALU_Ovf   = 1'b0;
    case (ALU_Sel)
      4'b0000: ALU_Out = ALU_A & ALU_B;
      4'b0001: ALU_Out = ALU_A | ALU_B;
      4'b0010: begin
        sum       = {1'b0, ALU_A} + {1'b0, ALU_B};
        ALU_Out   = sum[31:0];
        ALU_Carry = sum[32];
        ALU_Ovf   = (ALU_A[31] == ALU_B[31]) && (sum[31] != ALU_A[31]);
      end
      4'b0110: ALU_Out = ALU_A - ALU_B;
      4'b0111: ALU_Out = {31'b0, $signed(ALU_A) < $signed(ALU_B)};
      4'b1100: ALU_Out = ~(ALU_A | ALU_B);
      4'b1111: ALU_Out = {31'b0, ALU_A == ALU_B};
      default: ALU_Out = '0;
    endcase
    ALU_Zero = (ALU_Out == 32'h0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] second_ack;

  initial begin
`ifdef ALU_SHARE_ARB_FIXED_PRI_EN
    second_ack = 2'b01;
`else
    second_ack = 2'b10;
`endif
    // reset state
    tick(); tick();
    chk("rst_busy", {31'b0, Busy}, 0);
    chk("rst_ack", {30'b0, Req_Ack}, 0);
    chk("rst_done", {30'b0, Done}, 0);
    chk("rst_rsp", Rsp_Out, 0);
    chk("rst_alu_sel", {28'b0, ALU_Sel}, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_busy", {31'b0, Busy}, 0);

    // single ADD from req0
    Req_Valid = 2'b01; Req_A0 = 5; Req_B0 = 7; Req_Sel0 = 4'b0010;
    tick();
    chk("add_ack", {30'b0, Req_Ack}, 2'b01);
    chk("add_busy", {31'b0, Busy}, 1);
    chk("add_alu_a", ALU_A, 5);
    chk("add_done_early", {30'b0, Done}, 0);
    Req_Valid = 2'b00;
    tick();
    chk("add_done", {30'b0, Done}, 2'b01);
    chk("add_out", Rsp_Out, 12);
    chk("add_id", {31'b0, Rsp_Id}, 0);
    chk("add_zero", {31'b0, Rsp_Zero}, 0);
    chk("add_err", {31'b0, Rsp_Err}, 0);
    chk("add_ack_gone", {30'b0, Req_Ack}, 0);
    tick();
    chk("add_done_gone", {30'b0, Done}, 0);
    chk("add_busy_gone", {31'b0, Busy}, 0);
    chk("add_hold", Rsp_Out, 12);

    // contention from a fresh reset: 0, then 1, then 0
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    Req_Valid = 2'b11;
    Req_A0 = 3; Req_B0 = 3; Req_Sel0 = 4'b0110;
    Req_A1 = 32'hFFFF_FFFF; Req_B1 = 1; Req_Sel1 = 4'b0111;
    tick();
    chk("rr1_ack", {30'b0, Req_Ack}, 2'b01);
    tick();
    chk("rr1_done", {30'b0, Done}, 2'b01);
    chk("rr1_out", Rsp_Out, 0);
    chk("rr1_zero", {31'b0, Rsp_Zero}, 1);
    tick();
    chk("rr_resp_no_ack", {30'b0, Req_Ack}, 0);
    tick();
    chk("rr2_ack", {30'b0, Req_Ack}, {30'b0, second_ack});
    tick();
`ifndef ALU_SHARE_ARB_FIXED_PRI_EN
    chk("rr2_out", Rsp_Out, 1);
    chk("rr2_id", {31'b0, Rsp_Id}, 1);
    chk("rr2_done", {30'b0, Done}, 2'b10);
`endif
    tick(); tick();
    chk("rr3_ack", {30'b0, Req_Ack}, 2'b01);
    Req_Valid = 2'b00;
    tick(); tick();

    // req1 signed overflow, then unsigned carry
    Req_Valid = 2'b10; Req_A1 = 32'h7FFF_FFFF; Req_B1 = 1; Req_Sel1 = 4'b0010;
    tick();
    chk("ovf_ack", {30'b0, Req_Ack}, 2'b10);
    Req_Valid = 2'b00;
    tick();
    chk("ovf_out", Rsp_Out, 32'h8000_0000);
    chk("ovf_ovf", {31'b0, Rsp_Ovf}, 1);
    chk("ovf_carry", {31'b0, Rsp_Carry}, 0);
    chk("ovf_id", {31'b0, Rsp_Id}, 1);
    tick();
    Req_Valid = 2'b10; Req_A1 = 32'hFFFF_FFFF; Req_B1 = 1;
    tick();
    Req_Valid = 2'b00;
    tick();
    chk("cy_out", Rsp_Out, 0);
    chk("cy_carry", {31'b0, Rsp_Carry}, 1);
    chk("cy_zero", {31'b0, Rsp_Zero}, 1);
    chk("cy_ovf", {31'b0, Rsp_Ovf}, 0);
    tick();

    // illegal opcode from req0
    Req_Valid = 2'b01; Req_A0 = 32'hF; Req_B0 = 32'hF; Req_Sel0 = 4'b0011;
    tick();
    chk("ill_ack", {30'b0, Req_Ack}, 2'b01);
    chk("ill_alu_sel", {28'b0, ALU_Sel}, 0);
    Req_Valid = 2'b00;
    tick();
    chk("ill_done", {30'b0, Done}, 2'b01);
    chk("ill_err", {31'b0, Rsp_Err}, 1);
    chk("ill_out", Rsp_Out, 0);
    chk("ill_flags", {29'b0, Rsp_Carry, Rsp_Zero, Rsp_Ovf}, 0);
    tick();

    // reset during EXEC aborts the op
    Req_Valid = 2'b01; Req_A0 = 1; Req_B0 = 2; Req_Sel0 = 4'b0010;
    tick();
    chk("abort_ack", {30'b0, Req_Ack}, 2'b01);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_done", {30'b0, Done}, 0);
    chk("abort_busy", {31'b0, Busy}, 0);
    chk("abort_rsp", Rsp_Out, 0);
    Req_Valid = 2'b11; Req_A0 = 10; Req_B0 = 20;
    Req_A1 = 100; Req_B1 = 200; Req_Sel1 = 4'b0010;
    tick();
    chk("reissue_ack", {30'b0, Req_Ack}, 2'b01);
    Req_Valid = 2'b00;
    tick();
    chk("reissue_done", {30'b0, Done}, 2'b01);
    chk("reissue_out", Rsp_Out, 30);
    tick();
    chk("reissue_idle", {31'b0, Busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
